// File: rtl/washer_pkg.sv
// Shared definitions for the washer front-panel logic.
//   keypad_state_e : keypad scanner states
//   COL_IDLE       : column strobe value with no column driven
//   KEY_*          : key codes delivered by keypad_scan (row_idx*4 + col_idx)
// Helper functions decode active-low one-hot strobe/row patterns.
package washer_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } keypad_state_e;

    localparam logic [3:0] COL_IDLE  = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;
    localparam logic [3:0] ROW_IDLE  = 4'b1111;

    localparam logic [3:0] KEY_START      = 4'd0;
    localparam logic [3:0] KEY_MODE       = 4'd1;
    localparam logic [3:0] KEY_PAUSE      = 4'd2;
    localparam logic [3:0] KEY_CANCEL     = 4'd3;
    localparam logic [3:0] KEY_DIGIT_BASE = 4'd4;

    // Index of the lowest bit that is pulled low.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        if (!v[0]) return 2'd0;
        if (!v[1]) return 2'd1;
        if (!v[2]) return 2'd2;
        return 2'd3;
    endfunction

    // True when exactly one bit of an active-low pattern is asserted.
    function automatic logic single_low(input logic [3:0] v);
        logic [3:0] z;
        z = ~v;
        return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
    endfunction

    // Next column strobe: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] col_rotate(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// Dwell counter for time-sliced column/digit scanning.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : holds the counter at 0 (scan restart)
//   tick_o : high in the last cycle of each Dwell-cycle period
module keypad_tick #(
    parameter int unsigned Dwell = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(Dwell);
    localparam logic [CntW-1:0] Last = CntW'(Dwell - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == Last)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = (cnt_q == Last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 membrane keypad scanner with debounce.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   en        : scanning enable; low parks the columns at COL_IDLE
//   row       : keypad rows, active-low, asynchronous
//   col       : column strobes, active-low one-hot
//   key_code  : last accepted key, row_idx*4 + col_idx
//   key_valid : one-cycle pulse when key_code is (re)issued
//   key_held  : high while the accepted key is still down
// Build option: define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
module keypad_scan
    import washer_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100000000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 20,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_PERIOD  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned Dwell = CLK_HZ / SCAN_HZ;
    localparam logic [7:0]  DebN  = 8'(DEBOUNCE_SCANS);

    if (Dwell < 4 || DEBOUNCE_SCANS == 0 || DEBOUNCE_SCANS > 255 ||
        REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_params
        $error("keypad_scan: unsupported parameter set");
    end

    logic [3:0]    row_meta_q, rs_q;
    keypad_state_e state_q, state_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    cnt_inc;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;
    logic [3:0]    latched_pat;
    logic          tick;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RptW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    logic [RptW-1:0] rpt_q, rpt_d;
    logic [RptW-1:0] rpt_inc;
    assign rpt_inc = rpt_q + 1'b1;
`endif

    // The dwell counter is held at 0 while parked so a restart gets a full first dwell.
    keypad_tick #(
        .Dwell(Dwell)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (!en || (col_q == COL_IDLE)),
        .tick_o(tick)
    );

    assign cnt_inc     = cnt_q + 8'd1;
    assign latched_pat = ~(4'b0001 << row_idx_q);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_d     = rpt_q;
`endif
        if (!en) begin
            state_d = SCAN;
            col_d   = COL_IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_d   = '0;
`endif
        end else if (col_q == COL_IDLE) begin
            col_d = COL_FIRST;
        end else if (tick) begin
            unique case (state_q)
                SCAN: begin
                    // Multi-key (ghost) patterns are skipped like an idle column.
                    if (single_low(rs_q)) begin
                        row_idx_d = low_index(rs_q);
                        cnt_d     = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_rotate(col_q);
                    end
                end
                DEBOUNCE: begin
                    if (rs_q == latched_pat) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebN) begin
                            valid_d = 1'b1;
                            code_d  = {row_idx_q, low_index(col_q)};
                            held_d  = 1'b1;
                            state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            rpt_d   = '0;
`endif
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_rotate(col_q);
                    end
                end
                PRESSED: begin
                    if (rs_q[row_idx_q]) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        // First repeat at REPEAT_DELAY, then fold back every REPEAT_PERIOD.
                        rpt_d = rpt_inc;
                        if (rpt_inc == RptW'(REPEAT_DELAY)) begin
                            valid_d = 1'b1;
                        end else if (rpt_inc == RptW'(REPEAT_DELAY + REPEAT_PERIOD)) begin
                            valid_d = 1'b1;
                            rpt_d   = RptW'(REPEAT_DELAY);
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (rs_q == ROW_IDLE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebN) begin
                            held_d  = 1'b0;
                            state_d = SCAN;
                            col_d   = col_rotate(col_q);
`ifdef KEYPAD_REPEAT_EN
                            rpt_d   = '0;
`endif
                        end
                    end else if (!rs_q[row_idx_q]) begin
                        state_d = PRESSED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_q <= ROW_IDLE;
            rs_q       <= ROW_IDLE;
            state_q    <= SCAN;
            col_q      <= COL_FIRST;
            row_idx_q  <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            row_meta_q <= row;
            rs_q       <= row_meta_q;
            state_q    <= state_d;
            col_q      <= col_d;
            row_idx_q  <= row_idx_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign col       = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
`timescale 1ns/1ps
module tb_keypad_scan;

    localparam int DEB  = 3;
    localparam int RDLY = 5;
    localparam int RPER = 2;
    localparam int HUNT = 0, CONFIRM = 1, DOWN = 2, UP = 3;
    localparam logic [15:0] KEY9  = 16'h0200;  // row 2, col 1
    localparam logic [15:0] GHOST = 16'h0110;  // rows 1 and 2 in col 0

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic [3:0] row, col, key_code;
    logic key_valid, key_held;
    logic [15:0] keys = '0;  // bit r*4+c set = key at row r, col c pressed

    int n_checks = 0;
    int n_fail   = 0;
    int seen     = 0;
    logic stray;

    // Behavioural keypad model state
    int m_mode, m_col, m_row, m_cnt, m_since;
    logic [3:0] m_code;
    logic m_held, m_pulse;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    // Membrane matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    keypad_scan #(
        .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_SCANS(DEB),
        .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    function automatic logic [3:0] model_col();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << m_col);
    endfunction

    task automatic model_reset(input logic keep_code);
        m_mode = HUNT; m_col = 0; m_cnt = 0; m_since = 0;
        m_held = 1'b0; m_pulse = 1'b0;
        if (!keep_code) m_code = 4'd0;
    endtask

    // Advance the model by one scan tick, using the keys pressed during the dwell.
    task automatic model_tick();
        logic [3:0] pat;
        int lows;
        lows = 0;
        m_pulse = 1'b0;
        for (int r = 0; r < 4; r++) begin
            pat[r] = !keys[r*4+m_col];
            if (!pat[r]) lows++;
        end
        case (m_mode)
            HUNT: begin
                if (lows == 1) begin
                    for (int r = 0; r < 4; r++) if (!pat[r]) m_row = r;
                    m_cnt = 0; m_mode = CONFIRM;
                end else m_col = (m_col + 1) % 4;
            end
            CONFIRM: begin
                if (lows == 1 && !pat[m_row]) begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_pulse = 1'b1; m_code = 4'(m_row * 4 + m_col);
                        m_held = 1'b1; m_since = 0; m_mode = DOWN;
                    end
                end else begin
                    m_mode = HUNT; m_col = (m_col + 1) % 4;
                end
            end
            DOWN: begin
                if (pat[m_row]) begin
                    m_cnt = 0; m_mode = UP;
                end else begin
                    m_since++;
`ifdef KEYPAD_REPEAT_EN
                    if (m_since >= RDLY && (m_since - RDLY) % RPER == 0) m_pulse = 1'b1;
`endif
                end
            end
            default: begin
                if (lows == 0) begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_held = 1'b0; m_mode = HUNT; m_col = (m_col + 1) % 4; m_since = 0;
                    end
                end else if (!pat[m_row]) m_mode = DOWN;
            end
        endcase
    endtask

    // Apply a key pattern for one full dwell; ends 1 ns after the tick edge.
    task automatic run_tick(input logic [15:0] k);
        keys = k;
        stray = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i < 10 && key_valid === 1'b1) stray = 1'b1;
            if (key_valid === 1'b1) seen++;
        end
        model_tick();
    endtask

    function automatic int idle_to(input int target);
        return (target - m_col + 4) % 4;
    endfunction

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; keys = '0;
        #12;
        n_checks += 4;
        if (col !== 4'b1110) begin n_fail++; $display("FAIL reset col: got %b expected 1110", col); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b expected 0", key_valid); end
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset held: got %b expected 0", key_held); end
        if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset code: got %0d expected 0", key_code); end
        @(negedge clk) rst = 1'b1;
        model_reset(1'b0);
    endtask

    task automatic test_scan_rotation();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b1101; exp_seq[1] = 4'b1011; exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            run_tick('0);
            n_checks += 3;
            if (col !== exp_seq[i]) begin n_fail++; $display("FAIL rotate col: got %b expected %b", col, exp_seq[i]); end
            if (col !== model_col()) begin n_fail++; $display("FAIL rotate model_col: got %b expected %b", col, model_col()); end
            if (key_valid !== 1'b0 || stray) begin n_fail++; $display("FAIL rotate valid: got %b expected 0", key_valid); end
        end
    endtask

    task automatic test_press_release();
        q.delete();
        repeat (idle_to(1)) q.push_back('0);
        repeat (5) q.push_back(KEY9);
        q.push_back('0); q.push_back(KEY9);
        repeat (4) q.push_back('0);
        seen = 0;
        foreach (q[i]) begin
            run_tick(q[i]);
            n_checks += 5;
            if (col !== model_col()) begin n_fail++; $display("FAIL press col: got %b expected %b", col, model_col()); end
            if (key_valid !== m_pulse) begin n_fail++; $display("FAIL press valid: got %b expected %b", key_valid, m_pulse); end
            if (key_held !== m_held) begin n_fail++; $display("FAIL press held: got %b expected %b", key_held, m_held); end
            if (key_code !== m_code) begin n_fail++; $display("FAIL press code: got %0d expected %0d", key_code, m_code); end
            if (stray) begin n_fail++; $display("FAIL press stray_valid: got 1 expected 0"); end
        end
        n_checks += 3;
        if (seen !== 1) begin n_fail++; $display("FAIL press pulse_count: got %0d expected 1", seen); end
        if (key_code !== 4'd9) begin n_fail++; $display("FAIL press final_code: got %0d expected 9", key_code); end
        if (col !== 4'b1011) begin n_fail++; $display("FAIL press final_col: got %b expected 1011", col); end
    endtask

    task automatic test_bounce_and_ghost();
        q.delete();
        repeat (idle_to(1)) q.push_back('0);
        q.push_back(KEY9); q.push_back('0);   // bounce leaves col at 2
        repeat (2) q.push_back('0);           // col 2 -> col 0
        repeat (4) q.push_back(GHOST);
        seen = 0;
        foreach (q[i]) begin
            run_tick(q[i]);
            n_checks += 4;
            if (col !== model_col()) begin n_fail++; $display("FAIL bounce col: got %b expected %b", col, model_col()); end
            if (key_valid !== m_pulse) begin n_fail++; $display("FAIL bounce valid: got %b expected %b", key_valid, m_pulse); end
            if (key_held !== m_held) begin n_fail++; $display("FAIL bounce held: got %b expected %b", key_held, m_held); end
            if (stray) begin n_fail++; $display("FAIL bounce stray_valid: got 1 expected 0"); end
        end
        n_checks += 2;
        if (seen !== 0) begin n_fail++; $display("FAIL bounce pulse_count: got %0d expected 0", seen); end
        if (col !== 4'b1110) begin n_fail++; $display("FAIL ghost final_col: got %b expected 1110", col); end
    endtask

    task automatic test_hold_repeat();
        int exp_pulses;
`ifdef KEYPAD_REPEAT_EN
        exp_pulses = 4;
`else
        exp_pulses = 1;
`endif
        q.delete();
        repeat (idle_to(1)) q.push_back('0);
        repeat (14) q.push_back(KEY9);
        repeat (4) q.push_back('0);
        seen = 0;
        foreach (q[i]) begin
            run_tick(q[i]);
            n_checks += 4;
            if (col !== model_col()) begin n_fail++; $display("FAIL hold col: got %b expected %b", col, model_col()); end
            if (key_valid !== m_pulse) begin n_fail++; $display("FAIL hold valid: got %b expected %b", key_valid, m_pulse); end
            if (key_held !== m_held) begin n_fail++; $display("FAIL hold held: got %b expected %b", key_held, m_held); end
            if (stray) begin n_fail++; $display("FAIL hold stray_valid: got 1 expected 0"); end
        end
        n_checks++;
        if (seen !== exp_pulses) begin n_fail++; $display("FAIL hold pulse_count: got %0d expected %0d", seen, exp_pulses); end
    endtask

    task automatic test_enable();
        q.delete();
        repeat (idle_to(1)) q.push_back('0);
        repeat (5) q.push_back(KEY9);
        foreach (q[i]) begin
            run_tick(q[i]);
            n_checks += 3;
            if (col !== model_col()) begin n_fail++; $display("FAIL enable col: got %b expected %b", col, model_col()); end
            if (key_valid !== m_pulse) begin n_fail++; $display("FAIL enable valid: got %b expected %b", key_valid, m_pulse); end
            if (key_held !== m_held) begin n_fail++; $display("FAIL enable held: got %b expected %b", key_held, m_held); end
        end
        en = 1'b0;
        @(posedge clk); #1;
        n_checks += 4;
        if (col !== 4'b1111) begin n_fail++; $display("FAIL disable col: got %b expected 1111", col); end
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL disable held: got %b expected 0", key_held); end
        if (key_code !== 4'd9) begin n_fail++; $display("FAIL disable code: got %0d expected 9", key_code); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL disable valid: got %b expected 0", key_valid); end
        keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) en = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (col !== 4'b1110) begin n_fail++; $display("FAIL reenable col: got %b expected 1110", col); end
        model_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            run_tick('0);
            n_checks += 2;
            if (col !== model_col()) begin n_fail++; $display("FAIL reenable step_col: got %b expected %b", col, model_col()); end
            if (key_code !== m_code) begin n_fail++; $display("FAIL reenable code: got %0d expected %0d", key_code, m_code); end
        end
    endtask

    task automatic test_async_reset();
        q.delete();
        repeat (idle_to(1)) q.push_back('0);
        repeat (4) q.push_back(KEY9);
        foreach (q[i]) run_tick(q[i]);
        n_checks++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL areset pre_held: got %b expected 1", key_held); end
        #3 rst = 1'b0;
        #1;
        n_checks += 4;
        if (col !== 4'b1110) begin n_fail++; $display("FAIL areset col: got %b expected 1110", col); end
        if (key_code !== 4'd0) begin n_fail++; $display("FAIL areset code: got %0d expected 0", key_code); end
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL areset held: got %b expected 0", key_held); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL areset valid: got %b expected 0", key_valid); end
        @(negedge clk);
        keys = '0;
        rst = 1'b1;
        model_reset(1'b0);
        for (int i = 0; i < 2; i++) begin
            run_tick('0);
            n_checks++;
            if (col !== model_col()) begin n_fail++; $display("FAIL areset step_col: got %b expected %b", col, model_col()); end
        end
    endtask

    task automatic test_random();
        logic [15:0] pat;
        int dur;
        q.delete();
        while (q.size() < 90) begin
            case ($urandom_range(0, 3))
                0: pat = '0;
                1, 2: pat = 16'h0001 << $urandom_range(0, 15);
                default: pat = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            endcase
            dur = $urandom_range(1, 7);
            repeat (dur) q.push_back(pat);
        end
        foreach (q[i]) begin
            run_tick(q[i]);
            n_checks += 5;
            if (col !== model_col()) begin n_fail++; $display("FAIL random col: got %b expected %b", col, model_col()); end
            if (key_valid !== m_pulse) begin n_fail++; $display("FAIL random valid: got %b expected %b", key_valid, m_pulse); end
            if (key_held !== m_held) begin n_fail++; $display("FAIL random held: got %b expected %b", key_held, m_held); end
            if (key_code !== m_code) begin n_fail++; $display("FAIL random code: got %0d expected %0d", key_code, m_code); end
            if (stray) begin n_fail++; $display("FAIL random stray_valid: got 1 expected 0"); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_rotation();
        test_press_release();
        test_bounce_and_ghost();
        test_hold_repeat();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
